// File: rtl/bch_128_pkg.sv
// Shared constants, error classes and counter helper for the 144->128 BCH monitor slice.
package bch_128_pkg;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned CODE_W = 144;

    typedef enum logic [1:0] {CLEAN, CORR, ANOM, FATAL} err_class_e;

    // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/bch_128_word_fifo.sv
// Synchronous word FIFO; a push into a full FIFO is only taken when a pop frees a slot.
module bch_128_word_fifo #(
    parameter int unsigned WIDTH = 129,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_eff, pop_eff;

    always_comb begin
        pop_eff  = pop_i & (count_q != '0);
        push_eff = push_i & ((count_q != CNT_W'(DEPTH)) | pop_eff);
        count_d  = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_eff) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/bch_128_err_monitor.sv
// Classifies decoded BCH words, keeps saturating event counters and a sticky irq,
// and buffers words toward the consumer.
module bch_128_err_monitor
    import bch_128_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned CORR_THRESH = 8,
    parameter int unsigned DROP_FATAL  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              i_valid,
    input  logic [0:DATA_W-1] i_data,
    input  logic              i_err_corr,
    input  logic              i_err_detec,
    input  logic              i_err_fatal,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [0:DATA_W-1] o_data,
    output logic              o_fatal,
    output logic [CNT_W-1:0]  o_corr_cnt,
    output logic [CNT_W-1:0]  o_fatal_cnt,
    output logic [CNT_W-1:0]  o_anom_cnt,
    output logic [CNT_W-1:0]  o_drop_cnt,
    output logic              o_overflow,
    output logic              o_irq,
    input  logic              i_clear
);

    localparam int unsigned     FIFO_W     = DATA_W + 1;
    localparam int unsigned     FCNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CorrThresh = CNT_W'(CORR_THRESH);

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(32'(v), CNT_W));
    endfunction

    err_class_e        cls;
    logic              accept, push, pop, drop, fifo_full;
    logic [FIFO_W-1:0] fifo_head;
    logic [FCNT_W-1:0] fifo_count;

    logic [CNT_W-1:0] corr_q, corr_d, fatal_q, fatal_d, anom_q, anom_d, drop_q, drop_d;
    logic [CNT_W-1:0] corr_base, fatal_base, anom_base, drop_base;
    logic             ovf_q, ovf_d, irq_q, irq_d;

    always_comb begin
        if (i_err_fatal)      cls = FATAL;
        else if (i_err_corr)  cls = CORR;
        else if (i_err_detec) cls = ANOM;
        else                  cls = CLEAN;
    end

    assign accept = i_valid & enable;
    assign push   = accept & ~((cls == FATAL) && (DROP_FATAL != 0));
    assign pop    = o_valid & o_ready;
    assign drop   = push & fifo_full & ~pop;

    bch_128_word_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (push),
        .data_i  ({cls == FATAL, i_data}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign o_valid = (fifo_count != '0);
    assign o_fatal = fifo_head[DATA_W];
    assign o_data  = fifo_head[DATA_W-1:0];

    // Clear is applied first so a same-cycle event lands on the zeroed value.
    always_comb begin
        corr_base  = i_clear ? '0 : corr_q;
        fatal_base = i_clear ? '0 : fatal_q;
        anom_base  = i_clear ? '0 : anom_q;
        drop_base  = i_clear ? '0 : drop_q;
        corr_d     = (accept && cls == CORR)  ? bump(corr_base)  : corr_base;
        fatal_d    = (accept && cls == FATAL) ? bump(fatal_base) : fatal_base;
        anom_d     = (accept && cls == ANOM)  ? bump(anom_base)  : anom_base;
        drop_d     = drop ? bump(drop_base) : drop_base;
        ovf_d      = (i_clear ? 1'b0 : ovf_q) | drop;
        irq_d      = (i_clear ? 1'b0 : irq_q)
                   | (accept && cls == FATAL)
                   | (accept && cls == CORR && corr_d >= CorrThresh);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            corr_q  <= '0;
            fatal_q <= '0;
            anom_q  <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            corr_q  <= corr_d;
            fatal_q <= fatal_d;
            anom_q  <= anom_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
        end
    end

    assign o_corr_cnt  = corr_q;
    assign o_fatal_cnt = fatal_q;
    assign o_anom_cnt  = anom_q;
    assign o_drop_cnt  = drop_q;
    assign o_overflow  = ovf_q;
    assign o_irq       = irq_q;

endmodule

// File: doc/bch_128_err_monitor.md
Name: bch_128_err_monitor

Overview:
Downstream consumer of the 144→128 BCH decoder output. Classifies each decoded word as clean, corrected, uncorrectable (fatal) or detect-only anomaly, and keeps saturating event counters. Raises a sticky interrupt at a corrected-error threshold or on any fatal error. Buffers decoded words in a small FIFO with valid/ready toward the consumer, because the decoder has no backpressure.

Parameters:
DEPTH, 4, FIFO entries (power of 2, ≥2)
CNT_W, 16, width of each event counter
CORR_THRESH, 8, corrected-error count that fires the interrupt (1..2^CNT_W-1)
DROP_FATAL, 0, 1 = discard fatal words (still counted); 0 = forward with o_fatal tag

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  monitor enable; when low, inputs are ignored
i_valid  in  1  decoder output word valid
i_data  in  [0:127]  decoded data word
i_err_corr  in  1  decoder: error corrected
i_err_detec  in  1  decoder: error detected
i_err_fatal  in  1  decoder: uncorrectable error
o_valid  out  1  FIFO head valid
o_ready  in  1  consumer accepts head
o_data  out  [0:127]  FIFO head data
o_fatal  out  1  head word was flagged fatal
o_corr_cnt  out  CNT_W  corrected-word count
o_fatal_cnt  out  CNT_W  fatal-word count
o_anom_cnt  out  CNT_W  detect-only anomaly count
o_drop_cnt  out  CNT_W  words lost to FIFO overflow
o_overflow  out  1  sticky: at least one word dropped
o_irq  out  1  sticky interrupt
i_clear  in  1  synchronous clear of counters and sticky flags

Behaviour:
- Reset: the clock is clk; reset is asynchronous, active-low, and named reset_n. Reset clears all counters, o_irq, o_overflow, the FIFO pointers and occupancy, o_valid, o_data and o_fatal to 0.
- Accepted input: i_valid=1 and enable=1. Otherwise nothing is pushed or counted.
- Classification, in priority order:
  - fatal if i_err_fatal;
  - else corrected if i_err_corr;
  - else anomaly if i_err_detec;
  - else clean.
- Counters saturate at 2^CNT_W-1 and never wrap.
- i_clear:
  - Zeroes all counters, o_irq and o_overflow in the same cycle.
  - If an event arrives in the same cycle, the affected counter loads 1 and the irq/overflow rules are evaluated on the post-clear values.
  - i_clear does not touch the FIFO.
- o_irq:
  - Sets on the cycle after an accepted fatal word.
  - Also sets on the cycle the corrected counter transitions to a value ≥ CORR_THRESH.
  - Holds until i_clear.
- FIFO:
  - Synchronous, DEPTH entries, 129 bits each ({fatal, data}).
  - Push = accepted word, unless it is fatal and DROP_FATAL=1.
  - Pop = o_valid & o_ready.
  - Latency is 1 cycle: a word pushed in cycle N is visible at the head in cycle N+1 when the FIFO was empty. There is no combinational bypass.
  - o_valid = (count != 0). o_data/o_fatal are the head entry and are stable while o_valid=1 and o_ready=0.
- Full FIFO:
  - Push with no pop in the same cycle: the word is dropped, o_drop_cnt increments, o_overflow sets. The word is still classified and counted.
  - Push with a simultaneous pop: accepted, count unchanged.
- Empty FIFO: pop is ignored (o_valid=0).
- Pointers wrap modulo DEPTH. Count runs 0..DEPTH.
- enable deasserted mid-stream: pushes stop, but the FIFO continues draining, and counters and flags hold.
- reset_n asserted mid-operation: immediate clear of all state. Words still in the FIFO are lost.

Decomposition:
- Shared package bch_128_pkg holds:
  - constants DATA_W=128 and CODE_W=144;
  - the error-class enum {CLEAN, CORR, ANOM, FATAL};
  - a saturating-increment function.
- One sub-module, bch_128_word_fifo (parameterised width/depth, push/pop, full/empty/count), holds the buffering. The top level contains classification, counters and interrupt logic.

Test Plan:
- Reset, then 3 clean words 128'h1, 128'h2, 128'h3 with o_ready=1 → o_data shows 1, 2, 3 on consecutive cycles, each 1 cycle after input; all counters 0; o_irq=0.
- 8 words with i_err_corr=1, CORR_THRESH=8 → o_corr_cnt reaches 8; o_irq rises the cycle after the 8th word; 7 words leave o_irq=0.
- One word with i_err_fatal=1 (i_err_detec=1 too) → o_fatal_cnt=1, o_irq=1.
  - DROP_FATAL=0: word exits with o_fatal=1.
  - DROP_FATAL=1: FIFO stays empty.
- o_ready=0, push 6 clean words, DEPTH=4 → 4 stored, o_drop_cnt=2, o_overflow=1; then o_ready=1 drains the first 4 words in order.
- Full FIFO with o_ready=1 and a push in the same cycle → no drop, count stays 4; detect-only word (i_err_detec=1 only) → o_anom_cnt=1.
- i_clear pulsed in the same cycle as a corrected word with o_corr_cnt=5 → o_corr_cnt=1, o_irq=0; reset_n pulsed low mid-burst → all outputs 0 immediately; enable=0 with i_valid=1 → no push, no count.
